// File: rtl/sobel_frame_readout.sv
// Result capture and readout for the Sobel engine: forwards and counts engine writes,
// then streams the cropped frame from output memory over valid/ready with a last marker.
module sobel_frame_readout #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 16,
    parameter int IMAGE_ROW_SIZE    = 256,
    parameter int IMAGE_COLUMN_SIZE = 256,
    parameter int KERNEL_SIZE       = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  eng_wr_en_i,
    input  logic [ADDR_WIDTH-1:0] eng_addr_i,
    input  logic [DATA_WIDTH-1:0] eng_data_i,
    input  logic                  eng_finish_i,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH:0]   wr_count_o,
    output logic                  done_o,
    output logic [2:0]            err_o
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int N_INT = (IMAGE_ROW_SIZE - KERNEL_SIZE + 1) * (IMAGE_COLUMN_SIZE - KERNEL_SIZE + 1);
    localparam logic [CW-1:0] N       = CW'(N_INT);
    localparam logic [CW-1:0] LAST    = N - CW'(1);
    localparam logic [CW-1:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {CAPTURE, DRAIN, DONE} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         wr_count, wr_count_inc, rp, pop_cnt;
    logic                  addr_ok, wr_ok, rd_issue, pop, rd_vld_p1;
    logic [1:0]            fcnt, occ;
    logic                  wptr, rptr;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic [2:0]            err, err_set;

    assign addr_ok      = {1'b0, eng_addr_i} < N;
    assign wr_ok        = (state == CAPTURE) && eng_wr_en_i && addr_ok;
    assign wr_count_inc = (wr_ok && (wr_count != CNT_MAX)) ? wr_count + CW'(1) : wr_count;

    assign out_valid_o  = (state == DRAIN) && (fcnt != 2'd0);
    assign out_data_o   = out_valid_o ? fifo_q[rptr] : '0;
    assign out_last_o   = out_valid_o && (pop_cnt == LAST);
    assign pop          = out_valid_o && out_ready_i;

    // Occupancy is taken after this cycle's pop so a steady stream keeps one read in flight.
    assign occ          = fcnt + 2'(rd_vld_p1) - 2'(pop);
    assign rd_issue     = (state == DRAIN) && (rp < N) && (occ < 2'd2);

    assign wr_count_o   = wr_count;
    assign done_o       = (state == DONE);
    assign err_o        = err;

    always_comb begin
        state_next  = state;
        mem_wr_en_o = 1'b0;
        mem_addr_o  = '0;
        mem_data_o  = '0;
        err_set     = 3'b000;
        case (state)
            CAPTURE: begin
                mem_addr_o  = eng_addr_i;
                mem_data_o  = eng_data_i;
                mem_wr_en_o = wr_ok;
                err_set[0]  = eng_wr_en_i && !addr_ok;
                if (eng_finish_i) begin
                    state_next = DRAIN;
                    err_set[1] = (wr_count_inc != N);
                end
            end
            DRAIN: begin
                mem_addr_o = rp[ADDR_WIDTH-1:0];
                err_set[2] = eng_wr_en_i;
                if (pop && (pop_cnt == LAST)) state_next = DONE;
            end
            DONE: begin
                err_set[2] = eng_wr_en_i;
            end
            default: state_next = CAPTURE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= CAPTURE;
            wr_count  <= '0;
            rp        <= '0;
            pop_cnt   <= '0;
            rd_vld_p1 <= 1'b0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            fcnt      <= 2'd0;
            err       <= 3'b000;
        end else begin
            state     <= state_next;
            wr_count  <= wr_count_inc;
            err       <= err | err_set;
            rd_vld_p1 <= rd_issue;
            if (rd_issue)  rp <= rp + CW'(1);
            if (rd_vld_p1) wptr <= ~wptr;
            if (pop) begin
                rptr    <= ~rptr;
                pop_cnt <= pop_cnt + CW'(1);
            end
            fcnt <= fcnt + 2'(rd_vld_p1) - 2'(pop);
        end
    end

    // Stage p1: registered memory read data lands in the skid FIFO
    always_ff @(posedge clk_i) begin
        if (rd_vld_p1) fifo_q[wptr] <= mem_rdata_i;
    end

endmodule

// File: tb/tb_sobel_frame_readout.sv
// Directed bench for sobel_frame_readout on a 6x6 image with a 3x3 kernel (16-pixel result frame).
module tb_sobel_frame_readout;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        eng_wr_en_i = 1'b0;
    logic [15:0] eng_addr_i = '0;
    logic [7:0]  eng_data_i = '0;
    logic        eng_finish_i = 1'b0;
    logic        mem_wr_en_o;
    logic [15:0] mem_addr_o;
    logic [7:0]  mem_data_o;
    logic [7:0]  mem_rdata_i = '0;
    logic        out_valid_o;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic        out_ready_i = 1'b0;
    logic [16:0] wr_count_o;
    logic        done_o;
    logic [2:0]  err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] tbmem  [64];
    logic [7:0] exp_px [16];

    always #5 clk_i = ~clk_i;

    sobel_frame_readout #(
        .DATA_WIDTH(8), .ADDR_WIDTH(16),
        .IMAGE_ROW_SIZE(6), .IMAGE_COLUMN_SIZE(6), .KERNEL_SIZE(3)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .eng_wr_en_i(eng_wr_en_i), .eng_addr_i(eng_addr_i), .eng_data_i(eng_data_i),
        .eng_finish_i(eng_finish_i),
        .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_rdata_i(mem_rdata_i),
        .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .out_ready_i(out_ready_i),
        .wr_count_o(wr_count_o), .done_o(done_o), .err_o(err_o)
    );

    // Output memory with one-cycle registered read
    always @(posedge clk_i) begin
        if (mem_wr_en_o) tbmem[mem_addr_o[5:0]] <= mem_data_o;
        mem_rdata_i <= tbmem[mem_addr_o[5:0]];
    end

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        eng_wr_en_i = 1'b0;
        eng_finish_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        eng_wr_en_i = 1'b1;
        eng_addr_i  = a;
        eng_data_i  = d;
        #1;
        chk("wr_fwd_en", 32'(mem_wr_en_o), (a < 16'd16) ? 32'd1 : 32'd0);
        if (a < 16'd16) exp_px[a[3:0]] = d;
        @(negedge clk_i);
        eng_wr_en_i = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] base, input int skip);
        for (int i = 0; i < 16; i++)
            if (i != skip) wr(16'(i), base + 8'(i));
    endtask

    task automatic finish();
        eng_finish_i = 1'b1;
        @(negedge clk_i);
        eng_finish_i = 1'b0;
        #1;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1. inject: cycle of a stray engine write.
    task automatic drain(input int nbeats, input int mode, input int inject);
        int beat = 0;
        int cyc = 0;
        logic held_v = 1'b0;
        logic [7:0] held = '0;
        while (beat < nbeats && cyc < 200) begin
            out_ready_i = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            eng_wr_en_i = (cyc == inject);
            eng_addr_i  = 16'd3;
            eng_data_i  = 8'hEE;
            #1;
            if (cyc == inject) chk("drain_wr_blocked", 32'(mem_wr_en_o), 32'd0);
            if (held_v) chk("stall_hold", {23'd0, out_valid_o, out_data_o}, {23'd0, 1'b1, held});
            if (out_valid_o && out_ready_i) begin
                chk("beat_data", 32'(out_data_o), 32'(exp_px[beat]));
                chk("beat_last", 32'(out_last_o), (beat == 15) ? 32'd1 : 32'd0);
                beat++;
                held_v = 1'b0;
            end else if (out_valid_o) begin
                held_v = 1'b1;
                held   = out_data_o;
            end else begin
                held_v = 1'b0;
            end
            @(negedge clk_i);
            cyc++;
        end
        eng_wr_en_i = 1'b0;
        #1;
        chk("beat_count", 32'(beat), 32'(nbeats));
    endtask

    task automatic check_done();
        chk("done_high", 32'(done_o), 32'd1);
        chk("done_valid_low", 32'(out_valid_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbmem[i] = 8'h00;
        for (int i = 0; i < 16; i++) exp_px[i] = 8'h00;

        do_reset();
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_count", 32'(wr_count_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr_en_o), 32'd0);

        // Clean frame, entry latency, full-rate stream
        write_frame(8'h10, -1);
        chk("s1_count_pre", 32'(wr_count_o), 32'd16);
        finish();
        chk("s1_count", 32'(wr_count_o), 32'd16);
        chk("s1_err", 32'(err_o), 32'd0);
        chk("s1_done_low", 32'(done_o), 32'd0);
        chk("s1_valid_t0", 32'(out_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("s1_valid_t1", 32'(out_valid_o), 32'd0);
        @(negedge clk_i); #1;
        chk("s1_valid_t2", 32'(out_valid_o), 32'd1);
        chk("s1_first_data", 32'(out_data_o), 32'h10);
        drain(16, 0, -1);
        check_done();
        chk("s1_count_done", 32'(wr_count_o), 32'd16);

        // Same frame under 1,0,0,1 backpressure
        do_reset();
        write_frame(8'h10, -1);
        finish();
        drain(16, 1, -1);
        check_done();
        chk("s2_err", 32'(err_o), 32'd0);

        // Out-of-range write then a full frame
        do_reset();
        wr(16'd16, 8'hAA);
        chk("s3_err0_early", 32'(err_o), 32'd1);
        write_frame(8'h10, -1);
        finish();
        chk("s3_count", 32'(wr_count_o), 32'd16);
        chk("s3_err", 32'(err_o), 32'b001);
        drain(16, 0, -1);
        check_done();

        // Short frame: address 7 never written, old pixel streams out
        do_reset();
        write_frame(8'h30, 7);
        finish();
        chk("s4_count", 32'(wr_count_o), 32'd15);
        chk("s4_err", 32'(err_o), 32'b010);
        chk("s4_px7", 32'(exp_px[7]), 32'h17);
        drain(16, 0, -1);
        check_done();

        // Stray engine write during drain
        do_reset();
        write_frame(8'h50, -1);
        finish();
        drain(16, 0, 4);
        check_done();
        chk("s5_err", 32'(err_o), 32'b100);
        chk("s5_count", 32'(wr_count_o), 32'd16);

        // Reset after five beats, then a clean frame
        do_reset();
        write_frame(8'h10, -1);
        finish();
        drain(5, 0, -1);
        rst_i = 1'b1;
        out_ready_i = 1'b0;
        @(negedge clk_i); #1;
        chk("s6_valid", 32'(out_valid_o), 32'd0);
        chk("s6_count", 32'(wr_count_o), 32'd0);
        chk("s6_err", 32'(err_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        write_frame(8'h10, -1);
        finish();
        chk("s6_count2", 32'(wr_count_o), 32'd16);
        chk("s6_err2", 32'(err_o), 32'd0);
        drain(16, 0, -1);
        check_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
